// File: rtl/jtsdram_bank_sched_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : jtsdram_bank_sched_if                                          |
// | Purpose  : Control/status bundle between a run controller (master) and   |
// |            the JTSDRAM bank scheduler (slave), plus the checker-facing   |
// |            start/done/bad vectors.                                       |
// | Signals  : enable, mode, passes              master -> slave             |
// |            bank_done, bank_bad               checkers -> slave           |
// |            bank_start                        slave -> checkers           |
// |            busy, finished, timeout,                                      |
// |            cur_bank, pass_cnt, bad_mask      slave -> master             |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface jtsdram_bank_sched_if #(
   parameter int BANKS = 4,
   parameter int PASSW = 8,
   parameter int CBW   = (BANKS > 1) ? $clog2(BANKS) : 1
);
   logic             enable;
   logic             mode;
   logic [PASSW-1:0] passes;
   logic [BANKS-1:0] bank_done;
   logic [BANKS-1:0] bank_bad;
   logic [BANKS-1:0] bank_start;
   logic             busy;
   logic             finished;
   logic             timeout;
   logic [CBW-1:0]   cur_bank;
   logic [PASSW-1:0] pass_cnt;
   logic [BANKS-1:0] bad_mask;

   modport master (
      output enable, mode, passes, bank_done, bank_bad,
      input  bank_start, busy, finished, timeout, cur_bank, pass_cnt, bad_mask
   );

   modport slave (
      input  enable, mode, passes, bank_done, bank_bad,
      output bank_start, busy, finished, timeout, cur_bank, pass_cnt, bad_mask
   );
endinterface
`default_nettype wire

// File: rtl/jtsdram_bank_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : jtsdram_bank_sched                                             |
// | Purpose  : Run-level sequencer for the SDRAM bank checkers. Pulses the   |
// |            checkers (one bank at a time or all together), waits for     |
// |            their sticky done, accumulates sticky bad flags, counts      |
// |            passes and stops after the requested number. A watchdog      |
// |            ends the run if a checker never finishes.                    |
// | Ports    : clk      system clock                                        |
// |            rst_n    synchronous active-low reset                        |
// |            bus      jtsdram_bank_sched_if.slave (control, checker        |
// |                     vectors and status outputs, all outputs registered) |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module jtsdram_bank_sched #(
   parameter int BANKS = 4,
   parameter int PASSW = 8,
   parameter int TOUTW = 24
) (
   input  wire                   clk,
   input  wire                   rst_n,
   jtsdram_bank_sched_if.slave   bus
);
   localparam int CBW = (BANKS > 1) ? $clog2(BANKS) : 1;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_RUN   = 3'd2;
   localparam logic [2:0] S_NEXT  = 3'd3;
   localparam logic [2:0] S_END   = 3'd4;

   localparam logic [CBW-1:0] C_LAST_BANK = CBW'(BANKS - 1);

   logic [2:0]       state_q,    state_d;
   logic             mode_q,     mode_d;
   logic [PASSW-1:0] passes_q,   passes_d;
   logic [CBW-1:0]   cur_bank_q, cur_bank_d;
   logic [PASSW-1:0] pass_cnt_q, pass_cnt_d;
   logic [BANKS-1:0] bad_mask_q, bad_mask_d;
   logic             timeout_q,  timeout_d;
   logic             finished_q, finished_d;
   logic [TOUTW-1:0] wd_q,       wd_d;
   logic [BANKS-1:0] start_q,    start_d;
   logic             busy_q,     busy_d;

   logic             w_done;
   logic [BANKS-1:0] w_bank_sel;

   assign w_bank_sel = BANKS'(1) << cur_bank_q;
   assign w_done     = mode_q ? (&bus.bank_done) : bus.bank_done[cur_bank_q];

   always_comb begin
      state_d    = state_q;
      mode_d     = mode_q;
      passes_d   = passes_q;
      cur_bank_d = cur_bank_q;
      pass_cnt_d = pass_cnt_q;
      bad_mask_d = bad_mask_q;
      timeout_d  = timeout_q;
      finished_d = finished_q;
      wd_d       = wd_q;

      case (state_q)
         S_IDLE: begin
            if (bus.enable && !finished_q) begin
               mode_d     = bus.mode;
               passes_d   = bus.passes;
               pass_cnt_d = '0;
               bad_mask_d = '0;
               timeout_d  = 1'b0;
               cur_bank_d = '0;
               state_d    = S_START;
            end else if (!bus.enable) begin
               // enable low in IDLE re-arms the next run
               finished_d = 1'b0;
            end
         end
         S_START: begin
            wd_d    = '0;
            state_d = bus.enable ? S_RUN : S_IDLE;
         end
         S_RUN: begin
            if (!bus.enable) begin
               state_d = S_IDLE;
            end else if (w_done) begin
               // completion beats a watchdog expiring on the same cycle
               if (mode_q) bad_mask_d = bad_mask_q | bus.bank_bad;
               else        bad_mask_d = bad_mask_q | (bus.bank_bad & w_bank_sel);
               state_d = S_NEXT;
            end else if (&wd_q) begin
               timeout_d  = 1'b1;
               finished_d = 1'b1;
               state_d    = S_END;
            end else begin
               wd_d = wd_q + 1'b1;
            end
         end
         S_NEXT: begin
            if (!bus.enable) begin
               state_d = S_IDLE;
            end else if (!mode_q && (cur_bank_q != C_LAST_BANK)) begin
               cur_bank_d = cur_bank_q + 1'b1;
               state_d    = S_START;
            end else begin
               cur_bank_d = '0;
               pass_cnt_d = pass_cnt_q + 1'b1;
               if ((passes_q != '0) && (pass_cnt_d == passes_q)) begin
                  finished_d = 1'b1;
                  state_d    = S_END;
               end else begin
                  state_d = S_START;
               end
            end
         end
         S_END: begin
            if (!bus.enable) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Outputs are registered alongside the state they belong to, so the
      // start pulse is visible exactly while the FSM sits in START.
      start_d = '0;
      if (state_d == S_START)
         start_d = mode_d ? {BANKS{1'b1}} : (BANKS'(1) << cur_bank_d);
      busy_d = (state_d == S_START) || (state_d == S_RUN) || (state_d == S_NEXT);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         mode_q     <= 1'b0;
         passes_q   <= '0;
         cur_bank_q <= '0;
         pass_cnt_q <= '0;
         bad_mask_q <= '0;
         timeout_q  <= 1'b0;
         finished_q <= 1'b0;
         wd_q       <= '0;
         start_q    <= '0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         mode_q     <= mode_d;
         passes_q   <= passes_d;
         cur_bank_q <= cur_bank_d;
         pass_cnt_q <= pass_cnt_d;
         bad_mask_q <= bad_mask_d;
         timeout_q  <= timeout_d;
         finished_q <= finished_d;
         wd_q       <= wd_d;
         start_q    <= start_d;
         busy_q     <= busy_d;
      end
   end

   assign bus.bank_start = start_q;
   assign bus.busy       = busy_q;
   assign bus.finished   = finished_q;
   assign bus.timeout    = timeout_q;
   assign bus.cur_bank   = cur_bank_q;
   assign bus.pass_cnt   = pass_cnt_q;
   assign bus.bad_mask   = bad_mask_q;
endmodule
`default_nettype wire

// File: tb/tb_jtsdram_bank_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_jtsdram_bank_sched                                          |
// | Purpose  : Scoreboard bench for jtsdram_bank_sched with simple checker   |
// |            models: expected start pulses (mask and spacing) are queued  |
// |            by the stimulus and compared by an independent monitor.      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_jtsdram_bank_sched;
   localparam int BANKS = 4;
   localparam int PASSW = 8;
   localparam int TOUTW = 6;

   logic clk;
   logic rst_n;

   jtsdram_bank_sched_if #(.BANKS(BANKS), .PASSW(PASSW)) bus ();

   jtsdram_bank_sched #(.BANKS(BANKS), .PASSW(PASSW), .TOUTW(TOUTW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Checker models: done/bad cleared on start, done rises dly cycles later
   // (dly=0 means the checker never finishes).
   int         dly   [BANKS];
   logic [BANKS-1:0] bad_v;
   logic       preset;
   logic [BANKS-1:0] done_r, bad_r;
   int         cnt   [BANKS];

   initial begin
      done_r = '0;
      bad_r  = '0;
      for (int i = 0; i < BANKS; i++) cnt[i] = 0;
   end

   always @(posedge clk) begin
      for (int i = 0; i < BANKS; i++) begin
         if (bus.bank_start[i]) begin
            done_r[i] <= 1'b0;
            bad_r[i]  <= 1'b0;
            cnt[i]    <= dly[i];
         end else if (cnt[i] == 1) begin
            done_r[i] <= 1'b1;
            bad_r[i]  <= bad_v[i];
            cnt[i]    <= 0;
         end else if (cnt[i] != 0) begin
            cnt[i] <= cnt[i] - 1;
         end else if (preset) begin
            done_r[i] <= 1'b1;
         end
      end
   end

   assign bus.bank_done = done_r;
   assign bus.bank_bad  = bad_r;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic [BANKS-1:0] mask;
      int               gap;
   } exp_t;
   exp_t exp_q[$];
   int   last_start_cyc = 0;

   task automatic push(input logic [BANKS-1:0] m, input int g);
      exp_t e;
      e.mask = m;
      e.gap  = g;
      exp_q.push_back(e);
   endtask

   // Monitor: every observed start pulse must match the next queued entry.
   always @(negedge clk) begin
      if (rst_n && (bus.bank_start != '0)) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_start actual=%b required=none (t=%0t)",
                     bus.bank_start, $time);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("start_mask", int'(bus.bank_start), int'(e.mask));
            if (e.gap >= 0) chk("start_gap", cyc - last_start_cyc, e.gap);
         end
         last_start_cyc = cyc;
      end
   end

   task automatic wait_fin(input int bound, output int dcyc);
      int n = 0;
      while (!bus.finished && n < bound) begin
         @(negedge clk); #1;
         n++;
      end
      chk("finished_seen", int'(bus.finished), 1);
      dcyc = cyc - last_start_cyc;
   endtask

   task automatic wait_q_empty(input int bound);
      int n = 0;
      while (exp_q.size() != 0 && n < bound) begin
         @(negedge clk); #1;
         n++;
      end
      chk("starts_pending", exp_q.size(), 0);
   endtask

   task automatic idle_n(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic set_dly(input int a, input int b, input int c, input int d);
      dly[0] = a; dly[1] = b; dly[2] = c; dly[3] = d;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_start"},    int'(bus.bank_start), 0);
      chk({tag, "_busy"},     int'(bus.busy),       0);
      chk({tag, "_finished"}, int'(bus.finished),   0);
      chk({tag, "_timeout"},  int'(bus.timeout),    0);
      chk({tag, "_cur_bank"}, int'(bus.cur_bank),   0);
      chk({tag, "_pass_cnt"}, int'(bus.pass_cnt),   0);
      chk({tag, "_bad_mask"}, int'(bus.bad_mask),   0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "simulation time limit");
   end

   int d;

   initial begin
      rst_n      = 1'b0;
      bus.enable = 1'b0;
      bus.mode   = 1'b0;
      bus.passes = '0;
      preset     = 1'b0;
      bad_v      = '0;
      set_dly(10, 10, 10, 10);
      idle_n(3);
      chk_all_zero("reset");
      rst_n = 1'b1;
      idle_n(2);

      // 1: sequential, two passes, done 10 cycles after each start
      bus.mode = 1'b0; bus.passes = 8'd2;
      for (int p = 0; p < 2; p++)
         for (int b = 0; b < BANKS; b++)
            push(BANKS'(1) << b, (p == 0 && b == 0) ? -1 : 13);
      bus.enable = 1'b1;
      wait_fin(400, d);
      chk("t1_end_latency", d, 13);
      chk("t1_pass_cnt", int'(bus.pass_cnt), 2);
      chk("t1_bad_mask", int'(bus.bad_mask), 0);
      chk("t1_timeout",  int'(bus.timeout),  0);
      chk("t1_busy",     int'(bus.busy),     0);
      chk("t1_q_empty",  exp_q.size(),       0);
      bus.enable = 1'b0;
      idle_n(3);
      chk("t1_rearm_finished", int'(bus.finished), 0);

      // 2: concurrent, one pass, staggered done, bank 2 bad
      bus.mode = 1'b1; bus.passes = 8'd1;
      set_dly(5, 9, 20, 7);
      bad_v = 4'b0100;
      push(4'b1111, -1);
      bus.enable = 1'b1;
      wait_fin(200, d);
      chk("t2_end_latency", d, 23);
      chk("t2_bad_mask", int'(bus.bad_mask), 4);
      chk("t2_pass_cnt", int'(bus.pass_cnt), 1);
      chk("t2_timeout",  int'(bus.timeout),  0);
      chk("t2_q_empty",  exp_q.size(),       0);
      bus.enable = 1'b0;
      idle_n(3);

      // 3: sequential, bank 1 never finishes -> watchdog
      bus.mode = 1'b0; bus.passes = 8'd1;
      set_dly(10, 0, 10, 10);
      bad_v = '0;
      push(4'b0001, -1);
      push(4'b0010, 13);
      bus.enable = 1'b1;
      wait_fin(300, d);
      chk("t3_timeout_latency", d, 65);
      chk("t3_timeout",  int'(bus.timeout),  1);
      chk("t3_cur_bank", int'(bus.cur_bank), 1);
      chk("t3_pass_cnt", int'(bus.pass_cnt), 0);
      chk("t3_q_empty",  exp_q.size(),       0);
      bus.enable = 1'b0;
      idle_n(3);

      // 4: endless passes, abort during RUN after three full passes
      bus.mode = 1'b0; bus.passes = 8'd0;
      set_dly(4, 4, 4, 4);
      for (int k = 0; k < 13; k++)
         push(BANKS'(1) << (k % BANKS), (k == 0) ? -1 : 7);
      bus.enable = 1'b1;
      wait_q_empty(300);
      idle_n(2);
      bus.enable = 1'b0;
      idle_n(10);
      chk("t4_busy",     int'(bus.busy),     0);
      chk("t4_pass_cnt", int'(bus.pass_cnt), 3);
      chk("t4_finished", int'(bus.finished), 0);
      chk("t4_cur_bank", int'(bus.cur_bank), 0);

      // 5: stale done held high before the run, then reset mid-RUN
      set_dly(6, 6, 6, 6);
      preset = 1'b1;
      idle_n(1);
      preset = 1'b0;
      idle_n(1);
      chk("t5_stale_done", int'(bus.bank_done), 15);
      bus.mode = 1'b0; bus.passes = 8'd1;
      push(4'b0001, -1);
      push(4'b0010, 9);
      push(4'b0100, 9);
      push(4'b1000, 9);
      bus.enable = 1'b1;
      wait_fin(200, d);
      chk("t5_end_latency", d, 9);
      chk("t5_pass_cnt", int'(bus.pass_cnt), 1);
      bus.enable = 1'b0;
      idle_n(3);
      push(4'b0001, -1);
      bus.enable = 1'b1;
      wait_q_empty(20);
      idle_n(3);
      chk("t5_busy_mid_run", int'(bus.busy), 1);
      rst_n      = 1'b0;
      bus.enable = 1'b0;
      idle_n(1);
      chk_all_zero("midreset");
      rst_n = 1'b1;
      idle_n(3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire
